// File: rtl/ibex_pkg.sv
// ibex_pkg (performance-counter slice)
// Purpose : shared CSR address map and counter constants for the machine
//           performance counters.
// Ports   : none (package).
package ibex_pkg;

  // CSR addresses handled by the performance-counter block.
  typedef enum logic [11:0] {
    CSR_MCOUNTINHIBIT = 12'h320,
    CSR_MCYCLE        = 12'hB00,
    CSR_MINSTRET      = 12'hB02,
    CSR_MCYCLEH       = 12'hB80,
    CSR_MINSTRETH     = 12'hB82
  } csr_num_e;

  // Counter windows: (addr & CSR_MASK_MCOUNTER) selects the low-half or
  // high-half window, and addr[4:0] selects the counter inside it.
  localparam logic [11:0] CSR_OFF_MCOUNTER  = 12'hB00;
  localparam logic [11:0] CSR_OFF_MCOUNTERH = 12'hB80;
  localparam logic [11:0] CSR_MASK_MCOUNTER = 12'hFE0;

  // mhpmcounter3..31
  localparam int unsigned MHPM_COUNTER_NUM_MAX = 29;

  // Index 1 of each counter window (time/timeh) is not owned by this block.
  function automatic logic is_counter_slot(input logic [11:0] addr, input logic [11:0] off);
    return ((addr & CSR_MASK_MCOUNTER) == off) && (addr[4:0] != 5'd1);
  endfunction

endpackage

// File: rtl/ibex_counter.sv
// ibex_counter
// Purpose : one Width-bit event counter with separately writable 32-bit
//           halves. A write to either half takes priority over an increment
//           in the same cycle. The counter wraps to zero from all-ones.
// Ports   : clk_i, rst_i  - clock, synchronous active-high reset
//           incr          - add one this cycle
//           we_lo, we_hi  - replace bits [31:0] / [Width-1:32] with wdata
//           wdata         - 32-bit write data
//           value         - current counter value
module ibex_counter
  import ibex_pkg::*;
#(
  parameter int unsigned Width = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             incr,
  input  logic             we_lo,
  input  logic             we_hi,
  input  logic [31:0]      wdata,
  output logic [Width-1:0] value
);

  logic [Width-1:0] value_q;
  logic [Width-1:0] value_d;
  logic [63:0]      cur_ext;
  logic [63:0]      next_ext;
  logic             unused_next_ext;

  // Work on a 64-bit view so every legal Width shares one datapath; bits
  // above Width are dropped, which also makes written high bits vanish for
  // narrow counters and turns the all-ones increment into a wrap.
  assign cur_ext = 64'(value_q);

  // Next-value selection: write wins over increment, halves written independently.
  always_comb begin
    next_ext = cur_ext;
    if (we_lo || we_hi) begin
      next_ext[31:0]  = we_lo ? wdata : cur_ext[31:0];
      next_ext[63:32] = we_hi ? wdata : cur_ext[63:32];
    end else if (incr) begin
      next_ext = cur_ext + 64'd1;
    end else begin
      next_ext = cur_ext;
    end
  end

  assign value_d         = next_ext[Width-1:0];
  assign unused_next_ext = ^(next_ext >> Width);

  // Counter register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      value_q <= {Width{1'b0}};
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/ibex_perf_counters.sv
// ibex_perf_counters
// Purpose : machine performance counters: mcycle, minstret, mhpmcounter3..31
//           and mcountinhibit, with CSR read/write access.
// Ports   : clk_i, rst_i  - clock, synchronous active-high reset
//           csr_addr_i    - CSR address being accessed
//           csr_we_i      - full-word write strobe for csr_addr_i
//           csr_wdata_i   - resolved write data
//           instr_ret_i   - one instruction retired this cycle
//           hpm_event_i   - event strobes, bit k feeds mhpmcounter(k+3)
//           csr_hit_o     - csr_addr_i belongs to this block
//           csr_rdata_o   - combinational read data (pre-update value)
module ibex_perf_counters
  import ibex_pkg::*;
#(
  parameter int unsigned MHPMCounterNum   = 0,
  parameter int unsigned MHPMCounterWidth = 40
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [11:0] csr_addr_i,
  input  logic        csr_we_i,
  input  logic [31:0] csr_wdata_i,
  input  logic        instr_ret_i,
  input  logic [29:0] hpm_event_i,
  output logic        csr_hit_o,
  output logic [31:0] csr_rdata_o
);

  // Writable inhibit bits: mcycle (0), minstret (2) and implemented mhpm counters.
  localparam logic [31:0] InhibitMask =
      32'h0000_0005 | (((32'd1 << MHPMCounterNum) - 32'd1) << 3);

  logic [31:0] mcountinhibit_q;
  logic [31:0] mcountinhibit_d;
  logic [63:0] cnt_val [32];
  logic [63:0] mcycle_val;
  logic [63:0] minstret_val;
  logic        unused_hpm_event;

  // Events for unimplemented counters are deliberately dropped.
  assign unused_hpm_event = ^(hpm_event_i >> MHPMCounterNum);

  // mcountinhibit next state: masked full-word write, otherwise hold.
  always_comb begin
    if (csr_we_i && (csr_addr_i == CSR_MCOUNTINHIBIT)) begin
      mcountinhibit_d = csr_wdata_i & InhibitMask;
    end else begin
      mcountinhibit_d = mcountinhibit_q;
    end
  end

  // mcountinhibit register; gating uses this registered value, so a write
  // only affects increments from the following cycle on.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mcountinhibit_q <= 32'd0;
    end else begin
      mcountinhibit_q <= mcountinhibit_d;
    end
  end

  ibex_counter #(.Width(64)) u_mcycle (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .incr  (~mcountinhibit_q[0]),
    .we_lo (csr_we_i && (csr_addr_i == CSR_MCYCLE)),
    .we_hi (csr_we_i && (csr_addr_i == CSR_MCYCLEH)),
    .wdata (csr_wdata_i),
    .value (mcycle_val)
  );

  ibex_counter #(.Width(64)) u_minstret (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .incr  (instr_ret_i & ~mcountinhibit_q[2]),
    .we_lo (csr_we_i && (csr_addr_i == CSR_MINSTRET)),
    .we_hi (csr_we_i && (csr_addr_i == CSR_MINSTRETH)),
    .wdata (csr_wdata_i),
    .value (minstret_val)
  );

  // Read table indexed by addr[4:0]; slot 1 is never selected by the decoder.
  assign cnt_val[0] = mcycle_val;
  assign cnt_val[1] = 64'd0;
  assign cnt_val[2] = minstret_val;

  for (genvar k = 3; k < 32; k++) begin : g_mhpm
    if ((k - 3) < MHPMCounterNum) begin : g_impl
      logic [MHPMCounterWidth-1:0] value;

      ibex_counter #(.Width(MHPMCounterWidth)) u_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .incr  (hpm_event_i[k-3] & ~mcountinhibit_q[k]),
        .we_lo (csr_we_i && (csr_addr_i == (CSR_OFF_MCOUNTER + 12'(k)))),
        .we_hi (csr_we_i && (csr_addr_i == (CSR_OFF_MCOUNTERH + 12'(k)))),
        .wdata (csr_wdata_i),
        .value (value)
      );

      assign cnt_val[k] = 64'(value);
    end else begin : g_none
      assign cnt_val[k] = 64'd0;
    end
  end

  // CSR read decode: returns register state before any same-cycle update.
  always_comb begin
    csr_hit_o   = 1'b0;
    csr_rdata_o = 32'd0;
    if (csr_addr_i == CSR_MCOUNTINHIBIT) begin
      csr_hit_o   = 1'b1;
      csr_rdata_o = mcountinhibit_q;
    end else if (is_counter_slot(csr_addr_i, CSR_OFF_MCOUNTER)) begin
      csr_hit_o   = 1'b1;
      csr_rdata_o = cnt_val[csr_addr_i[4:0]][31:0];
    end else if (is_counter_slot(csr_addr_i, CSR_OFF_MCOUNTERH)) begin
      csr_hit_o   = 1'b1;
      csr_rdata_o = cnt_val[csr_addr_i[4:0]][63:32];
    end else begin
      csr_hit_o   = 1'b0;
      csr_rdata_o = 32'd0;
    end
  end

endmodule

// File: tb/tb_ibex_perf_counters.sv
// tb_ibex_perf_counters
// Purpose : self-checking bench for ibex_perf_counters (2 mhpm counters,
//           40 bits wide). Expected read results are queued when an access
//           is driven and popped when the combinational read is sampled.
module tb_ibex_perf_counters;
  import ibex_pkg::*;

  logic        clk;
  logic        rst;
  logic [11:0] csr_addr;
  logic        csr_we;
  logic [31:0] csr_wdata;
  logic        instr_ret;
  logic [29:0] hpm_event;
  logic        csr_hit;
  logic [31:0] csr_rdata;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    string       tag;
    logic [31:0] data;
    logic        hit;
  } exp_t;

  exp_t sb_q[$];

  ibex_perf_counters #(
    .MHPMCounterNum   (2),
    .MHPMCounterWidth (40)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .csr_addr_i  (csr_addr),
    .csr_we_i    (csr_we),
    .csr_wdata_i (csr_wdata),
    .instr_ret_i (instr_ret),
    .hpm_event_i (hpm_event),
    .csr_hit_o   (csr_hit),
    .csr_rdata_o (csr_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Queue the expectation for the access currently driven, then sample it.
  task automatic expect_rd(input string tag, input logic [31:0] d, input logic h);
    exp_t e;
    exp_t got;
    e.tag  = tag;
    e.data = d;
    e.hit  = h;
    sb_q.push_back(e);
    #1;
    got = sb_q.pop_front();
    check_eq(got.tag, csr_rdata, got.data);
    check_eq({got.tag, ".hit"}, {31'd0, csr_hit}, {31'd0, got.hit});
  endtask

  task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] d, input logic h);
    csr_we   = 1'b0;
    csr_addr = a;
    expect_rd(tag, d, h);
  endtask

  // Write for one cycle; the read during the write must show the old value.
  task automatic wr(input string tag, input logic [11:0] a, input logic [31:0] wd,
                    input logic [31:0] old, input logic h);
    csr_addr  = a;
    csr_wdata = wd;
    csr_we    = 1'b1;
    expect_rd({tag, ".old"}, old, h);
    step();
    csr_we = 1'b0;
  endtask

  task automatic pulse_hpm(input logic [29:0] ev);
    hpm_event = ev;
    step();
    hpm_event = 30'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    csr_addr  = 12'h000;
    csr_we    = 1'b0;
    csr_wdata = 32'd0;
    instr_ret = 1'b0;
    hpm_event = 30'd0;
    repeat (3) step();
    rst = 1'b0;

    // Reset state, then 10 idle cycles.
    rd("rst_mcycle",   CSR_MCYCLE,        32'd0, 1'b1);
    rd("rst_mcycleh",  CSR_MCYCLEH,       32'd0, 1'b1);
    rd("rst_minstret", CSR_MINSTRET,      32'd0, 1'b1);
    rd("rst_inhibit",  CSR_MCOUNTINHIBIT, 32'd0, 1'b1);
    repeat (10) step();
    rd("idle_mcycle",   CSR_MCYCLE,   32'd10, 1'b1);
    rd("idle_minstret", CSR_MINSTRET, 32'd0,  1'b1);

    // 64-bit wrap of mcycle.
    wr("wr_mcycle",  CSR_MCYCLE,  32'hFFFF_FFFF, 32'd10, 1'b1);
    wr("wr_mcycleh", CSR_MCYCLEH, 32'hFFFF_FFFF, 32'd0,  1'b1);
    rd("ones_mcycle",  CSR_MCYCLE,  32'hFFFF_FFFF, 1'b1);
    rd("ones_mcycleh", CSR_MCYCLEH, 32'hFFFF_FFFF, 1'b1);
    step();
    rd("wrap_mcycle",  CSR_MCYCLE,  32'd0, 1'b1);
    rd("wrap_mcycleh", CSR_MCYCLEH, 32'd0, 1'b1);

    // Inhibit gating takes effect one cycle after the write.
    instr_ret = 1'b1;
    step();
    wr("wr_inh5", CSR_MCOUNTINHIBIT, 32'h0000_0005, 32'd0, 1'b1);
    rd("inh_mcycle_a",   CSR_MCYCLE,        32'd2, 1'b1);
    rd("inh_minstret_a", CSR_MINSTRET,      32'd2, 1'b1);
    rd("inh_value",      CSR_MCOUNTINHIBIT, 32'd5, 1'b1);
    step();
    rd("inh_mcycle_b",   CSR_MCYCLE,   32'd2, 1'b1);
    rd("inh_minstret_b", CSR_MINSTRET, 32'd2, 1'b1);
    wr("wr_inh0", CSR_MCOUNTINHIBIT, 32'd0, 32'd5, 1'b1);
    rd("inh_mcycle_c",   CSR_MCYCLE,   32'd2, 1'b1);
    rd("inh_minstret_c", CSR_MINSTRET, 32'd2, 1'b1);
    step();
    rd("run_mcycle",   CSR_MCYCLE,   32'd3, 1'b1);
    rd("run_minstret", CSR_MINSTRET, 32'd3, 1'b1);

    // Write beats a same-cycle retire.
    wr("wr_minstret", CSR_MINSTRET, 32'h0000_0100, 32'd3, 1'b1);
    rd("ww_minstret",  CSR_MINSTRET,  32'h0000_0100, 1'b1);
    rd("ww_minstreth", CSR_MINSTRETH, 32'd0,         1'b1);
    step();
    rd("inc_minstret", CSR_MINSTRET, 32'h0000_0101, 1'b1);
    instr_ret = 1'b0;

    // Event counters; bit 5 targets an unimplemented counter.
    for (int i = 0; i < 3; i++) begin
      pulse_hpm(30'h22);
      step();
    end
    rd("hpm4",      12'hB04, 32'd3, 1'b1);
    rd("hpm3",      12'hB03, 32'd0, 1'b1);
    rd("hpm5",      12'hB05, 32'd0, 1'b1);
    rd("hpm8",      12'hB08, 32'd0, 1'b1);
    rd("hpm4h",     12'hB84, 32'd0, 1'b1);

    // Only implemented inhibit bits stick; inhibited event counter holds.
    wr("wr_inh_all", CSR_MCOUNTINHIBIT, 32'hFFFF_FFFF, 32'd0, 1'b1);
    rd("inh_mask", CSR_MCOUNTINHIBIT, 32'h0000_001D, 1'b1);
    pulse_hpm(30'h2);
    rd("hpm4_inh", 12'hB04, 32'd3, 1'b1);
    wr("wr_inh_clr", CSR_MCOUNTINHIBIT, 32'd0, 32'h0000_001D, 1'b1);

    // High half of a 40-bit counter, unimplemented writes, 40-bit wrap.
    wr("wr_hpm4h", 12'hB84, 32'hFFFF_FFFF, 32'd0, 1'b1);
    rd("hpm4h_ff", 12'hB84, 32'h0000_00FF, 1'b1);
    rd("hpm4_lo",  12'hB04, 32'd3,         1'b1);
    wr("wr_hpm5", 12'hB05, 32'h0000_1234, 32'd0, 1'b1);
    rd("hpm5_ign", 12'hB05, 32'd0, 1'b1);
    wr("wr_hpm4", 12'hB04, 32'hFFFF_FFFF, 32'd3, 1'b1);
    rd("hpm4_ones",  12'hB04, 32'hFFFF_FFFF, 1'b1);
    rd("hpm4h_ones", 12'hB84, 32'h0000_00FF, 1'b1);
    pulse_hpm(30'h2);
    rd("hpm4_wrap",  12'hB04, 32'd0, 1'b1);
    rd("hpm4h_wrap", 12'hB84, 32'd0, 1'b1);

    // Decode boundaries.
    wr("wr_b1f", 12'hB1F, 32'hFFFF_FFFF, 32'd0, 1'b1);
    rd("b1f", 12'hB1F, 32'd0, 1'b1);
    wr("wr_inh_b1", CSR_MCOUNTINHIBIT, 32'h0000_0002, 32'd0, 1'b1);
    rd("inh_b1", CSR_MCOUNTINHIBIT, 32'd0, 1'b1);
    wr("wr_b40", 12'hB40, 32'hFFFF_FFFF, 32'd0, 1'b0);
    rd("b40",      12'hB40,           32'd0, 1'b0);
    rd("b01",      12'hB01,           32'd0, 1'b0);
    rd("b81",      12'hB81,           32'd0, 1'b0);
    rd("inh_hold", CSR_MCOUNTINHIBIT, 32'd0, 1'b1);

    // Reset overrides a concurrent write, retire and event.
    rst       = 1'b1;
    csr_addr  = CSR_MCYCLE;
    csr_wdata = 32'h0000_0005;
    csr_we    = 1'b1;
    instr_ret = 1'b1;
    hpm_event = 30'h2;
    step();
    rst       = 1'b0;
    csr_we    = 1'b0;
    instr_ret = 1'b0;
    hpm_event = 30'd0;
    rd("rst2_mcycle",   CSR_MCYCLE,        32'd0, 1'b1);
    rd("rst2_minstret", CSR_MINSTRET,      32'd0, 1'b1);
    rd("rst2_hpm4",     12'hB04,           32'd0, 1'b1);
    rd("rst2_hpm4h",    12'hB84,           32'd0, 1'b1);
    rd("rst2_inhibit",  CSR_MCOUNTINHIBIT, 32'd0, 1'b1);
    step();
    rd("rst2_first_inc", CSR_MCYCLE, 32'd1, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
